// File: rtl/sarray_ld_arb_pkg.sv
// Shared widths, limits and arbiter types for the systolic-array load port.
// Imported by the load arbiter and its ID FIFO.
package sarray_ld_arb_pkg;

  localparam int ADDR_WIDTH        = 64;
  localparam int SARRAY_LOAD_WIDTH = 2048;
  localparam int SARRAY_LD_OUTST   = 4;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic {
    ARB_UNLOCKED = 1'b0,
    ARB_LOCKED   = 1'b1
  } arb_state_e;

  // Round-robin pick for an unlocked port.
  function automatic logic rr_pick(
    input logic v0,
    input logic v1,
    input logic rr_last
  );
    logic g;
    g = REQ_A;
    unique case (1'b1)
      (v0 && v1): g = ~rr_last;
      (v1 && !v0): g = REQ_B;
      default: g = REQ_A;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sarray_ld_arb_id_fifo.sv
// In-order requester-ID FIFO for the load arbiter.
// Pointers carry a wrap bit so full and empty are distinguishable.
module sarray_id_fifo
  import sarray_ld_arb_pkg::*;
#(
  parameter int DEPTH = SARRAY_LD_OUTST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      wr_ptr_r;
  logic [IW:0]      rd_ptr_r;
  logic [DEPTH-1:0] mem_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[IW-1:0]] <= din;
  end

  assign dout  = mem_r[rd_ptr_r[IW-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[IW] != rd_ptr_r[IW]) &&
                 (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/sarray_ld_arb.sv
// Round-robin AR arbiter with per-request lock for the sarray load port.
// Responses are steered back using an in-order ID FIFO.
module sarray_ld_arb
  import sarray_ld_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int DATA_W = SARRAY_LOAD_WIDTH,
  parameter int OUTST  = SARRAY_LD_OUTST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s0_ar_valid_i,
  output logic                     s0_ar_ready_o,
  input  logic [ADDR_W-1:0]        s0_ar_addr_i,
  input  logic                     s1_ar_valid_i,
  output logic                     s1_ar_ready_o,
  input  logic [ADDR_W-1:0]        s1_ar_addr_i,
  output logic                     s0_r_valid_o,
  input  logic                     s0_r_ready_i,
  output logic [DATA_W-1:0]        s0_r_data_o,
  output logic                     s1_r_valid_o,
  input  logic                     s1_r_ready_i,
  output logic [DATA_W-1:0]        s1_r_data_o,
  output logic                     sarray_ar_valid_o,
  input  logic                     sarray_ar_ready_i,
  output logic [ADDR_W-1:0]        sarray_ar_addr_o,
  input  logic                     sarray_r_valid_i,
  output logic                     sarray_r_ready_o,
  input  logic [DATA_W-1:0]        sarray_r_data_i,
  output logic [$clog2(OUTST):0]   outst_cnt_o
);

  arb_state_e state_r;
  arb_state_e state_nx;
  logic       gnt_r;
  logic       gnt_nx;
  logic       rr_last_r;
  logic       rr_last_nx;
  logic       gnt;
  logic       gnt_valid;
  logic       ar_hs;
  logic       r_hs;
  logic       full;
  logic       empty;
  logic       head;
  logic       head_ready;
  logic       r_live;

  assign gnt = (state_r == ARB_LOCKED) ? gnt_r :
               rr_pick(s0_ar_valid_i, s1_ar_valid_i, rr_last_r);

  assign gnt_valid = gnt ? s1_ar_valid_i : s0_ar_valid_i;

  // Outputs are held quiet while reset is asserted.
  assign sarray_ar_valid_o = rst_n & gnt_valid & ~full;
  assign sarray_ar_addr_o  = gnt ? s1_ar_addr_i : s0_ar_addr_i;
  assign s0_ar_ready_o     = rst_n & sarray_ar_ready_i & ~full & ~gnt;
  assign s1_ar_ready_o     = rst_n & sarray_ar_ready_i & ~full & gnt;
  assign ar_hs             = sarray_ar_valid_o & sarray_ar_ready_i;

  always_comb begin
    state_nx   = state_r;
    gnt_nx     = gnt_r;
    rr_last_nx = rr_last_r;
    unique case (state_r)
      ARB_UNLOCKED: begin
        if (ar_hs) begin
          rr_last_nx = gnt;
        end else if (sarray_ar_valid_o) begin
          state_nx = ARB_LOCKED;
          gnt_nx   = gnt;
        end
      end
      ARB_LOCKED: begin
        if (ar_hs) begin
          state_nx   = ARB_UNLOCKED;
          rr_last_nx = gnt;
        end
      end
      default: state_nx = ARB_UNLOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ARB_UNLOCKED;
      gnt_r     <= REQ_A;
      rr_last_r <= REQ_B;
    end else begin
      state_r   <= state_nx;
      gnt_r     <= gnt_nx;
      rr_last_r <= rr_last_nx;
    end
  end

  // Beats with no outstanding ID are never accepted or forwarded.
  assign head_ready       = head ? s1_r_ready_i : s0_r_ready_i;
  assign sarray_r_ready_o = rst_n & ~empty & head_ready;
  assign r_live           = rst_n & sarray_r_valid_i & ~empty;
  assign s0_r_valid_o     = r_live & ~head;
  assign s1_r_valid_o     = r_live & head;
  assign s0_r_data_o      = sarray_r_data_i;
  assign s1_r_data_o      = sarray_r_data_i;
  assign r_hs             = sarray_r_valid_i & sarray_r_ready_o;

  sarray_id_fifo #(
    .DEPTH (OUTST)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .din   (gnt),
    .pop   (r_hs),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (outst_cnt_o)
  );

endmodule

// File: tb/tb_sarray_ld_arb.sv
// Randomized bench for sarray_ld_arb against a queue-based reference.
// Directed phases exercise fill, contention, lock, backpressure and reset.
module tb_sarray_ld_arb;

  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int OUT = 4;
  localparam int CW  = $clog2(OUT) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          v0 = 1'b0, v1 = 1'b0;
  logic [AW-1:0] a0 = '0, a1 = '0;
  logic          arr = 1'b0, rv = 1'b0;
  logic          rr0 = 1'b0, rr1 = 1'b0;
  logic [DW-1:0] rd = '0;

  logic          s0_ar_ready, s1_ar_ready;
  logic          s0_r_valid, s1_r_valid;
  logic [DW-1:0] s0_r_data, s1_r_data;
  logic          ar_valid, r_ready;
  logic [AW-1:0] ar_addr;
  logic [CW-1:0] cnt;

  sarray_ld_arb #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .OUTST  (OUT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .s0_ar_valid_i     (v0),
    .s0_ar_ready_o     (s0_ar_ready),
    .s0_ar_addr_i      (a0),
    .s1_ar_valid_i     (v1),
    .s1_ar_ready_o     (s1_ar_ready),
    .s1_ar_addr_i      (a1),
    .s0_r_valid_o      (s0_r_valid),
    .s0_r_ready_i      (rr0),
    .s0_r_data_o       (s0_r_data),
    .s1_r_valid_o      (s1_r_valid),
    .s1_r_ready_i      (rr1),
    .s1_r_data_o       (s1_r_data),
    .sarray_ar_valid_o (ar_valid),
    .sarray_ar_ready_i (arr),
    .sarray_ar_addr_o  (ar_addr),
    .sarray_r_valid_i  (rv),
    .sarray_r_ready_o  (r_ready),
    .sarray_r_data_i   (rd),
    .outst_cnt_o       (cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: outstanding reads in issue order.
  bit            q_id[$];
  logic [AW-1:0] q_addr[$];
  int            held = -1;
  bit            rr_last = 1'b1;
  bit            pend0 = 1'b0, pend1 = 1'b0;
  bit            mem_hold = 1'b0;
  logic [AW-1:0] next_addr = 32'h1000;

  int p0, p1, par, prv, prr0, prr1;
  bit stray = 1'b0;

  function automatic logic [DW-1:0] tag_of(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  task automatic drive();
    if (!pend0 && $urandom_range(99) < p0) begin
      pend0 = 1'b1;
      a0 = next_addr;
      next_addr += 32'h100;
    end
    if (!pend1 && $urandom_range(99) < p1) begin
      pend1 = 1'b1;
      a1 = next_addr;
      next_addr += 32'h100;
    end
    v0  = pend0;
    v1  = pend1;
    arr = ($urandom_range(99) < par);
    rr0 = ($urandom_range(99) < prr0);
    rr1 = ($urandom_range(99) < prr1);
    if (mem_hold) begin
      rv = 1'b1;
    end else if (q_id.size() > 0 && $urandom_range(99) < prv) begin
      rv = 1'b1;
      rd = tag_of(q_addr[0]);
      mem_hold = 1'b1;
    end else if (q_id.size() == 0 && stray) begin
      rv = 1'b1;
      rd = {$urandom, $urandom};
    end else begin
      rv = 1'b0;
      rd = {$urandom, $urandom};
    end
  endtask

  task automatic cyc();
    bit full, empty, hd, g;
    bit e_arv, e_rd0, e_rd1, e_rr, e_rv0, e_rv1, arh, rh;
    drive();
    #3;
    full  = (q_id.size() >= OUT);
    empty = (q_id.size() == 0);
    hd    = empty ? 1'b0 : q_id[0];
    if (held >= 0)      g = held[0];
    else if (v0 && v1)  g = !rr_last;
    else                g = v1;
    e_arv = rst_n && (g ? v1 : v0) && !full;
    e_rd0 = rst_n && arr && !full && !g;
    e_rd1 = rst_n && arr && !full && g;
    e_rr  = rst_n && !empty && (hd ? rr1 : rr0);
    e_rv0 = rst_n && rv && !empty && !hd;
    e_rv1 = rst_n && rv && !empty && hd;
    chk("ar_valid", 64'(ar_valid), 64'(e_arv));
    if (e_arv) chk("ar_addr", 64'(ar_addr), 64'(g ? a1 : a0));
    chk("s0_ar_ready", 64'(s0_ar_ready), 64'(e_rd0));
    chk("s1_ar_ready", 64'(s1_ar_ready), 64'(e_rd1));
    chk("r_ready", 64'(r_ready), 64'(e_rr));
    chk("s0_r_valid", 64'(s0_r_valid), 64'(e_rv0));
    chk("s1_r_valid", 64'(s1_r_valid), 64'(e_rv1));
    chk("outst_cnt", 64'(cnt), 64'(q_id.size()));
    if (e_rv0 && rr0) chk("s0_beat", s0_r_data, tag_of(q_addr[0]));
    if (e_rv1 && rr1) chk("s1_beat", s1_r_data, tag_of(q_addr[0]));
    arh = e_arv && arr;
    rh  = (e_rv0 && rr0) || (e_rv1 && rr1);
    @(posedge clk);
    if (!rst_n) begin
      q_id.delete();
      q_addr.delete();
      held = -1;
      rr_last = 1'b1;
      mem_hold = 1'b0;
    end else begin
      if (rh) begin
        void'(q_id.pop_front());
        void'(q_addr.pop_front());
        mem_hold = 1'b0;
      end
      if (arh) begin
        q_id.push_back(g);
        q_addr.push_back(g ? a1 : a0);
        rr_last = g;
        held = -1;
        if (g) pend1 = 1'b0;
        else   pend0 = 1'b0;
      end else if (e_arv) begin
        held = int'(g);
      end
    end
    #1;
  endtask

  task automatic knobs(input int k0, input int k1, input int kar,
                       input int krv, input int kr0, input int kr1);
    p0 = k0; p1 = k1; par = kar; prv = krv; prr0 = kr0; prr1 = kr1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    knobs(100, 100, 100, 0, 100, 100);
    @(posedge clk);
    #1;
    run(2);
    rst_n = 1'b1;
    // single requester: fill to OUTST then stall, then drain
    knobs(100, 0, 100, 0, 100, 100);
    run(6);
    knobs(0, 0, 100, 100, 100, 100);
    run(6);
    // contention with immediate responses
    knobs(100, 100, 100, 100, 100, 100);
    run(20);
    knobs(0, 0, 100, 100, 100, 100);
    run(6);
    // lock: s0 waits on memory while s1 appears
    knobs(100, 0, 0, 0, 100, 100);
    run(1);
    knobs(100, 100, 0, 0, 100, 100);
    run(3);
    knobs(0, 0, 100, 0, 100, 100);
    run(3);
    // backpressure on s1 responses
    knobs(50, 50, 100, 100, 100, 0);
    run(15);
    knobs(0, 0, 100, 100, 100, 100);
    run(8);
    // full with simultaneous pop and pending AR
    knobs(100, 0, 100, 0, 100, 100);
    run(6);
    knobs(100, 0, 100, 100, 100, 100);
    run(6);
    // reset mid-stream, then stray response beats
    knobs(100, 100, 100, 0, 100, 100);
    run(2);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    knobs(0, 0, 0, 100, 100, 100);
    stray = 1'b1;
    run(3);
    stray = 1'b0;
    // long random mix
    knobs(40, 40, 60, 50, 70, 70);
    for (int blk = 0; blk < 20; blk++) begin
      knobs($urandom_range(90, 10), $urandom_range(90, 10),
            $urandom_range(100, 20), $urandom_range(100, 20),
            $urandom_range(100, 30), $urandom_range(100, 30));
      run(100);
    end
    knobs(0, 0, 100, 100, 100, 100);
    run(20);
    chk("drain_cnt", 64'(cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
